gimli_permutation_core: RTL and testbench

//  Iterative Gimli-384 permutation engine. Direct consumer of the per-column SP-box
//  (gimli_non_linear_permutation): applies the SP-box to the state columns, then the

---
 rtl/gimli_permutation_core.sv | 162 ++++++++++++++++
 tb/tb_gimli_permutation_core.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gimli_permutation_core.sv
// rtl/gimli_permutation_core.sv - Iterative Gimli-384 permutation engine with valid/ready handshakes
// Build option GIMLI_COLUMN_SERIAL_EN: one time-shared SP-box, one column per cycle.

module gimli_non_linear_permutation (
  input  logic [31:0] i_x,
  input  logic [31:0] i_y,
  input  logic [31:0] i_z,
  output logic [31:0] o_x,
  output logic [31:0] o_y,
  output logic [31:0] o_z
);
  logic [31:0] w_x;
  logic [31:0] w_y;

  assign w_x = {i_x[7:0], i_x[31:8]};
  assign w_y = {i_y[22:0], i_y[31:23]};

  assign o_z = w_x ^ (i_z << 1) ^ ((w_y & i_z) << 2);
  assign o_y = w_y ^ w_x ^ ((w_x | i_z) << 1);
  assign o_x = i_z ^ w_y ^ ((w_x & w_y) << 3);
endmodule

module gimli_permutation_core #(
  parameter int NUMBER_OF_ROUNDS = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [383:0] din_state,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [383:0] dout_state,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         busy
);
  localparam logic [31:0] RC_BASE = 32'h9e377900;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t       r_fsm;
  state_t       w_fsm_next;
  logic [383:0] r_state;
  logic [4:0]   r_round;
  logic [31:0]  w_word      [12];
  logic [31:0]  w_sp_word   [12];
  logic [31:0]  w_next_word [12];
  logic [383:0] w_next_state;
  logic         w_round_end;

  for (genvar i = 0; i < 12; i++) begin : g_pack
    assign w_word[i]                = r_state[32*i +: 32];
    assign w_next_state[32*i +: 32] = w_next_word[i];
  end

`ifdef GIMLI_COLUMN_SERIAL_EN
  logic [1:0]  r_col;
  logic [3:0]  w_col;
  logic [31:0] w_sx;
  logic [31:0] w_sy;
  logic [31:0] w_sz;

  assign w_col = {2'b00, r_col};

  gimli_non_linear_permutation u_sp (
    .i_x (w_word[w_col]),
    .i_y (w_word[w_col + 4'd4]),
    .i_z (w_word[w_col + 4'd8]),
    .o_x (w_sx),
    .o_y (w_sy),
    .o_z (w_sz)
  );

  always_comb begin
    w_sp_word                = w_word;
    w_sp_word[w_col]         = w_sx;
    w_sp_word[w_col + 4'd4]  = w_sy;
    w_sp_word[w_col + 4'd8]  = w_sz;
  end

  // Swaps and constant ride along with the column-3 write-back.
  assign w_round_end = (r_col == 2'd3);
`else
  logic [31:0] w_sx [4];
  logic [31:0] w_sy [4];
  logic [31:0] w_sz [4];

  for (genvar j = 0; j < 4; j++) begin : g_sp
    gimli_non_linear_permutation u_sp (
      .i_x (w_word[j]),
      .i_y (w_word[j+4]),
      .i_z (w_word[j+8]),
      .o_x (w_sx[j]),
      .o_y (w_sy[j]),
      .o_z (w_sz[j])
    );
  end

  always_comb begin
    w_sp_word = w_word;
    for (int j = 0; j < 4; j++) begin
      w_sp_word[j]   = w_sx[j];
      w_sp_word[j+4] = w_sy[j];
      w_sp_word[j+8] = w_sz[j];
    end
  end

  assign w_round_end = 1'b1;
`endif

  always_comb begin
    w_next_word = w_sp_word;
    if (w_round_end && (r_round[1:0] == 2'b00)) begin
      w_next_word[0] = w_sp_word[1] ^ RC_BASE ^ {27'd0, r_round};
      w_next_word[1] = w_sp_word[0];
      w_next_word[2] = w_sp_word[3];
      w_next_word[3] = w_sp_word[2];
    end else if (w_round_end && (r_round[1:0] == 2'b10)) begin
      w_next_word[0] = w_sp_word[2];
      w_next_word[1] = w_sp_word[3];
      w_next_word[2] = w_sp_word[0];
      w_next_word[3] = w_sp_word[1];
    end
  end

  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
      S_IDLE:  if (din_valid) w_fsm_next = S_RUN;
      S_RUN:   if (w_round_end && (r_round == 5'd1)) w_fsm_next = S_DONE;
      S_DONE:  if (dout_ready) w_fsm_next = S_IDLE;
      default: w_fsm_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm   <= S_IDLE;
      r_state <= '0;
      r_round <= '0;
`ifdef GIMLI_COLUMN_SERIAL_EN
      r_col   <= '0;
`endif
    end else begin
      r_fsm <= w_fsm_next;
      if ((r_fsm == S_IDLE) && din_valid) begin
        r_state <= din_state;
        r_round <= 5'(NUMBER_OF_ROUNDS);
      end else if (r_fsm == S_RUN) begin
        r_state <= w_next_state;
        if (w_round_end) r_round <= r_round - 5'd1;
`ifdef GIMLI_COLUMN_SERIAL_EN
        r_col <= r_col + 2'd1;
`endif
      end
    end
  end

  assign din_ready  = (r_fsm == S_IDLE);
  assign busy       = (r_fsm == S_RUN);
  assign dout_valid = (r_fsm == S_DONE);
  assign dout_state = r_state;
endmodule

// File: tb/tb_gimli_permutation_core.sv
// tb/tb_gimli_permutation_core.sv - Self-checking bench for gimli_permutation_core (24, 4 and 1 round instances)
module tb_gimli_permutation_core;
`ifdef GIMLI_COLUMN_SERIAL_EN
  localparam int STEP = 4;
`else
  localparam int STEP = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [383:0] din_state  [3];
  logic         din_valid  [3];
  logic         din_ready  [3];
  logic [383:0] dout_state [3];
  logic         dout_valid [3];
  logic         dout_ready [3];
  logic         busy       [3];

  logic [383:0] exp_state   [3];
  logic         exp_pending [3];
  int           n_chk = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    gimli_permutation_core #(.NUMBER_OF_ROUNDS(g == 0 ? 24 : (g == 1 ? 4 : 1))) u_dut (
      .clk        (clk),
      .rst        (rst),
      .din_state  (din_state[g]),
      .din_valid  (din_valid[g]),
      .din_ready  (din_ready[g]),
      .dout_state (dout_state[g]),
      .dout_valid (dout_valid[g]),
      .dout_ready (dout_ready[g]),
      .busy       (busy[g])
    );
  end

  function automatic int rounds_of(input int g);
    return (g == 0) ? 24 : ((g == 1) ? 4 : 1);
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Reference Gimli rounds first..last on a word array.
  function automatic logic [383:0] model(input logic [383:0] s, input int first, input int last);
    logic [31:0] w [12];
    logic [31:0] x, y, z, t;
    logic [383:0] res;
    for (int i = 0; i < 12; i++) w[i] = s[32*i +: 32];
    for (int r = first; r >= last; r--) begin
      for (int j = 0; j < 4; j++) begin
        x = rotl(w[j], 24);
        y = rotl(w[4+j], 9);
        z = w[8+j];
        w[8+j] = x ^ (z << 1) ^ ((y & z) << 2);
        w[4+j] = y ^ x ^ ((x | z) << 1);
        w[j]   = z ^ y ^ ((x & y) << 3);
      end
      if (r % 4 == 0) begin
        t = w[0]; w[0] = w[1]; w[1] = t;
        t = w[2]; w[2] = w[3]; w[3] = t;
        w[0] = w[0] ^ 32'h9e377900 ^ 32'(r);
      end else if (r % 4 == 2) begin
        t = w[0]; w[0] = w[2]; w[2] = t;
        t = w[1]; w[1] = w[3]; w[3] = t;
      end
    end
    for (int i = 0; i < 12; i++) res[32*i +: 32] = w[i];
    return res;
  endfunction

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Output compare against the model on every cycle the result is presented.
  always begin
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      if (!rst && dout_valid[g]) begin
        if (exp_pending[g]) begin
          check($sformatf("dout_state_dut%0d", g), dout_state[g], exp_state[g]);
          if (dout_ready[g]) exp_pending[g] = 1'b0;
        end else begin
          check($sformatf("dout_valid_unexpected_dut%0d", g), 384'(dout_valid[g]), 384'd0);
        end
      end
    end
  end

  task automatic accept(input int g, input logic [383:0] s, output int waited);
    din_state[g] = s;
    din_valid[g] = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!din_ready[g] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("din_ready_accept", 384'(din_ready[g]), 384'd1);
    exp_state[g]   = model(s, rounds_of(g), 1);
    exp_pending[g] = 1'b1;
    @(posedge clk);
    #1 din_valid[g] = 1'b0;
  endtask

  task automatic wait_done(input int g);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("busy_in_run", 384'(busy[g]), 384'd1);
    end while (!dout_valid[g] && lat < 1 + STEP * rounds_of(g) + 20);
    check($sformatf("latency_dut%0d", g), 384'(lat), 384'(1 + STEP * rounds_of(g)));
  endtask

  task automatic release_out(input int g, input int hold, input logic nv, input logic [383:0] ns);
    if (nv) begin
      din_state[g] = ns;
      din_valid[g] = 1'b1;
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_dout_valid", 384'(dout_valid[g]), 384'd1);
      if (nv) check("hold_din_ready", 384'(din_ready[g]), 384'd0);
    end
    @(posedge clk);
    #1 dout_ready[g] = 1'b1;
    @(posedge clk);
    #1 dout_ready[g] = 1'b0;
    check("dout_valid_drop", 384'(dout_valid[g]), 384'd0);
  endtask

  task automatic permute(input int g, input logic [383:0] s);
    int w;
    accept(g, s, w);
    wait_done(g);
    release_out(g, 0, 1'b0, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

  initial begin
    logic [383:0] kat, cur, a, b, m, one;
    logic [31:0]  word;
    int           w;

    for (int i = 0; i < 12; i++) kat[32*i +: 32] = 32'(i * i * i) + 32'(i) * 32'h9e3779b9;
    a = kat ^ {12{32'h0f1e2d3c}};
    b = {12{32'hdeadbeef}};
    one = 384'd1;

    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      din_state[g] = '0; din_valid[g] = 1'b0; dout_ready[g] = 1'b0;
      exp_state[g] = '0; exp_pending[g] = 1'b0;
    end
    #1;
    for (int g = 0; g < 3; g++) begin
      check("reset_din_ready", 384'(din_ready[g]), 384'd1);
      check("reset_dout_valid", 384'(dout_valid[g]), 384'd0);
      check("reset_busy", 384'(busy[g]), 384'd0);
      check("reset_dout_state", dout_state[g], '0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // Model pins: known-answer words and the r=4 round constant.
    m = model(kat, 24, 1);
    word = m[31:0];
    check("model_kat_w0", 384'(word), 384'(32'hba11c85a));
    word = m[63:32];
    check("model_kat_w1", 384'(word), 384'(32'h91bad119));
    m = model('0, 4, 4);
    check("model_r4_const", m, 384'(32'h9e377904));

    // Known answer on the 24-round core.
    accept(0, kat, w);
    wait_done(0);
    check("kat_w0", 384'(dout_state[0][31:0]), 384'(32'hba11c85a));
    check("kat_w1", 384'(dout_state[0][63:32]), 384'(32'h91bad119));
    release_out(0, 0, 1'b0, '0);

    // All-zero state, then 24 chained permutations.
    cur = '0;
    for (int k = 0; k < 24; k++) begin
      permute(0, cur);
      cur = model(cur, 24, 1);
    end

    // Backpressure with a pending new input.
    accept(0, a, w);
    wait_done(0);
    release_out(0, 10, 1'b1, b);
    accept(0, b, w);
    check("accept_after_handshake", 384'(w), 384'd0);
    wait_done(0);
    release_out(0, 0, 1'b0, '0);

    // Reset in the middle of the run.
    accept(0, a, w);
    repeat (12 * STEP) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun_din_ready", 384'(din_ready[0]), 384'd1);
    check("midrun_dout_valid", 384'(dout_valid[0]), 384'd0);
    check("midrun_busy", 384'(busy[0]), 384'd0);
    check("midrun_dout_state", dout_state[0], '0);
    exp_pending[0] = 1'b0;
    #1 rst = 1'b0;
    permute(0, kat);

    // Reduced-round instances.
    permute(1, kat);
    permute(1, '0);
    permute(1, a);
    accept(2, one, w);
    wait_done(2);
    check("r1_w0", 384'(dout_state[2][31:0]), 384'd0);
    check("r1_w4", 384'(dout_state[2][159:128]), 384'(32'h03000000));
    check("r1_w8", 384'(dout_state[2][287:256]), 384'(32'h01000000));
    release_out(2, 0, 1'b0, '0);
    permute(2, '0);
    permute(2, kat);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
